// File: rtl/distortion_pkg.sv
// Shared types and the makeup-gain helper for the multi-mode distortion.
package distortion_pkg;

    typedef enum logic [1:0] {
        DIST_SOFT = 2'd0,
        DIST_HARD = 2'd1,
        DIST_FOLD = 2'd2
    } dist_mode_e;

    typedef enum logic [1:0] {
        ST_BYPASS    = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_WET       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } dist_state_e;

    localparam int MAKEUP_W = 64;

    // Gain of 1 + 1/4 + 1/16, clamped to the largest positive sample of width dataW.
    function automatic logic [MAKEUP_W-1:0] makeup_sat(input logic [MAKEUP_W-1:0] s,
                                                       input int unsigned dataW);
        logic [MAKEUP_W-1:0] sum;
        logic [MAKEUP_W-1:0] lim;
        sum = s + (s >> 2) + (s >> 4);
        lim = (MAKEUP_W'(1) << (dataW - 1)) - MAKEUP_W'(1);
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/distortion_shaper.sv
// One channel of the first two pipeline stages: sign/magnitude, then the
// mode-dependent squash of the magnitude plus the clamp-point flag.
module distortion_shaper
    import distortion_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SOFT_THRESH = 15000000,
    parameter int HARD_THRESH = 30000000
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_x,
    output logic              o_sign,
    output logic [DATA_W-1:0] o_squash,
    output logic              o_clip
);

    localparam logic [DATA_W-1:0] T        = DATA_W'(SOFT_THRESH);
    localparam logic [DATA_W-1:0] H        = DATA_W'(HARD_THRESH);
    localparam logic [DATA_W-1:0] FOLD_TOP = T << 1;
    localparam logic [DATA_W-1:0] KNEE_CAP = T + ((H - T) >> 1);
    localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MAX  = {1'b1, {(DATA_W-1){1'b0}}};

    logic              r_sign;
    logic [DATA_W-1:0] r_abs;
    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] w_squash;
    logic              w_clip;

    // The most negative sample has no positive twin, so its magnitude pins at POS_MAX.
    always_comb begin
        w_abs = i_x;
        if (i_x[DATA_W-1]) begin
            w_abs = (i_x == NEG_MAX) ? POS_MAX : -i_x;
        end
    end

    always_comb begin
        w_squash = r_abs;
        w_clip   = 1'b0;
        if (i_mode == DIST_HARD) begin
            w_clip = (r_abs >= T);
            if (r_abs >= T) w_squash = T;
        end else if (i_mode == DIST_FOLD) begin
            w_clip = (r_abs >= FOLD_TOP);
            if (r_abs >= FOLD_TOP)  w_squash = '0;
            else if (r_abs >= T)    w_squash = FOLD_TOP - r_abs;
        end else begin
            w_clip = (r_abs >= H);
            if (r_abs >= H)         w_squash = KNEE_CAP;
            else if (r_abs >= T)    w_squash = T + ((r_abs - T) >> 1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sign   <= 1'b0;
            r_abs    <= '0;
            o_sign   <= 1'b0;
            o_squash <= '0;
            o_clip   <= 1'b0;
        end else begin
            r_sign   <= i_x[DATA_W-1];
            r_abs    <= w_abs;
            o_sign   <= r_sign;
            o_squash <= w_squash;
            o_clip   <= w_clip;
        end
    end

endmodule

// File: rtl/distortion_mm.sv
// N-channel, three-stage distortion with a dry/wet crossfade that ramps one
// step per output frame whenever the effect is switched on, off or re-moded.
module distortion_mm
    import distortion_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int N_CH        = 2,
    parameter int SOFT_THRESH = 15000000,
    parameter int HARD_THRESH = 30000000,
    parameter int RAMP_LOG2   = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic                   out_valid,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_clip,
    output logic                   fx_active
);

    localparam int FRAME_W = N_CH * DATA_W;
    localparam int LVL_W   = RAMP_LOG2 + 1;
    localparam int PROD_W  = DATA_W + RAMP_LOG2 + 3;
    localparam logic [LVL_W-1:0] LVL_MAX = {1'b1, {RAMP_LOG2{1'b0}}};

    logic               r_v1, r_v2;
    logic [FRAME_W-1:0] r_dry1, r_dry2;
    dist_state_e        r_state, w_state_next;
    logic [1:0]         r_mode_cur;
    logic [LVL_W-1:0]   r_level, w_level_next;
    logic               w_hold, w_step_up, w_step_dn;
    logic [N_CH-1:0]    w_sign, w_clip;
    logic [FRAME_W-1:0] w_squash, w_mix;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DATA_W-1:0]        w_m;
        logic [DATA_W-1:0]        w_out;
        logic signed [DATA_W-1:0] w_wet, w_dry;
        logic signed [DATA_W:0]   w_diff;
        logic signed [PROD_W-1:0] w_prod, w_sum;

        distortion_shaper #(
            .DATA_W      (DATA_W),
            .SOFT_THRESH (SOFT_THRESH),
            .HARD_THRESH (HARD_THRESH)
        ) u_shaper (
            .i_clk    (CLOCK_50),
            .i_resetn (resetn),
            .i_mode   (r_mode_cur),
            .i_x      (in_data[c*DATA_W +: DATA_W]),
            .o_sign   (w_sign[c]),
            .o_squash (w_squash[c*DATA_W +: DATA_W]),
            .o_clip   (w_clip[c])
        );

        // Level 0 makes the product vanish, so the dry sample passes bit-exact.
        always_comb begin
            w_m    = DATA_W'(makeup_sat(MAKEUP_W'(w_squash[c*DATA_W +: DATA_W]), DATA_W));
            w_wet  = w_sign[c] ? -$signed(w_m) : $signed(w_m);
            w_dry  = $signed(r_dry2[c*DATA_W +: DATA_W]);
            w_diff = (DATA_W+1)'(w_wet) - (DATA_W+1)'(w_dry);
            w_prod = PROD_W'(w_diff) * PROD_W'($signed({1'b0, r_level}));
            w_sum  = PROD_W'(w_dry) + (w_prod >>> RAMP_LOG2);
            if ((w_sum[PROD_W-1:DATA_W-1] == '0) || (w_sum[PROD_W-1:DATA_W-1] == '1))
                w_out = w_sum[DATA_W-1:0];
            else if (w_sum[PROD_W-1])
                w_out = {1'b1, {(DATA_W-1){1'b0}}};
            else
                w_out = {1'b0, {(DATA_W-1){1'b1}}};
        end

        assign w_mix[c*DATA_W +: DATA_W] = w_out;
    end

    assign w_hold    = enable && (mode == r_mode_cur);
    assign w_step_up = r_v2 && (r_state == ST_RAMP_UP)   && (r_level != LVL_MAX);
    assign w_step_dn = r_v2 && (r_state == ST_RAMP_DOWN) && (r_level != '0);
    assign fx_active = (r_level != '0);

    always_comb begin
        w_level_next = r_level;
        if (w_step_up)      w_level_next = r_level + LVL_W'(1);
        else if (w_step_dn) w_level_next = r_level - LVL_W'(1);
    end

    // Transitions look at the post-step level so a step and a state change can share an edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BYPASS:    if (enable) w_state_next = ST_RAMP_UP;
            ST_RAMP_UP:   if (!w_hold) w_state_next = ST_RAMP_DOWN;
                          else if (w_level_next == LVL_MAX) w_state_next = ST_WET;
            ST_WET:       if (!w_hold) w_state_next = ST_RAMP_DOWN;
            ST_RAMP_DOWN: if (w_hold) w_state_next = ST_RAMP_UP;
                          else if (w_level_next == '0) w_state_next = ST_BYPASS;
            default:      w_state_next = ST_BYPASS;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state    <= ST_BYPASS;
            r_level    <= '0;
            r_mode_cur <= 2'd0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_dry1     <= '0;
            r_dry2     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_clip   <= '0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
            if ((r_state == ST_BYPASS) && enable) r_mode_cur <= mode;
            r_v1      <= in_valid;
            r_v2      <= r_v1;
            r_dry1    <= in_data;
            r_dry2    <= r_dry1;
            out_valid <= r_v2;
            if (r_v2) begin
                out_data <= w_mix;
                out_clip <= w_clip;
            end
        end
    end

endmodule

// File: tb/tb_distortion_mm.sv
// Directed bench for distortion_mm with a short crossfade (RAMP_LOG2=2).
module tb_distortion_mm;

    localparam int DATA_W    = 32;
    localparam int N_CH      = 2;
    localparam int RAMP_LOG2 = 2;
    localparam logic [31:0] P20 = 32'd20000000;
    localparam logic [31:0] N40 = 32'(-40000000);

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        enable;
    logic [1:0]  mode;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_clip;
    logic        fx_active;

    int nChecks = 0;
    int nPass   = 0;

    logic [63:0] outQ[$];
    logic [1:0]  clipQ[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    distortion_mm #(
        .DATA_W      (DATA_W),
        .N_CH        (N_CH),
        .SOFT_THRESH (15000000),
        .HARD_THRESH (30000000),
        .RAMP_LOG2   (RAMP_LOG2)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .enable    (enable),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_clip  (out_clip),
        .fx_active (fx_active)
    );

    always @(negedge CLOCK_50) begin
        if (out_valid) begin
            outQ.push_back(out_data);
            clipQ.push_back(out_clip);
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic stream(input logic [63:0] frame, input int n);
        in_valid = 1'b1;
        in_data  = frame;
        repeat (n) @(negedge CLOCK_50);
        in_valid = 1'b0;
    endtask

    task automatic settle(input logic en, input logic [1:0] m, input logic [63:0] frame);
        enable = en;
        mode   = m;
        stream(frame, 12);
        idle(4);
        outQ.delete();
        clipQ.delete();
    endtask

    task automatic test_reset;
        resetn = 1'b0; enable = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge CLOCK_50);
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); else nPass++;
        nChecks++; if (out_data !== 64'd0) $display("[TB] FAIL reset_data: got %h expected 0", out_data); else nPass++;
        nChecks++; if (out_clip !== 2'b00) $display("[TB] FAIL reset_clip: got %b expected 00", out_clip); else nPass++;
        nChecks++; if (fx_active !== 1'b0) $display("[TB] FAIL reset_fx: got %b expected 0", fx_active); else nPass++;

        resetn = 1'b1; enable = 1'b1;
        in_valid = 1'b1; in_data = {P20, P20};
        repeat (6) @(negedge CLOCK_50);
        nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL prereset_valid: got %b expected 1", out_valid); else nPass++;
        nChecks++; if (fx_active !== 1'b1) $display("[TB] FAIL prereset_fx: got %b expected 1", fx_active); else nPass++;

        resetn = 1'b0;
        @(negedge CLOCK_50);
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL midreset_valid: got %b expected 0", out_valid); else nPass++;
        nChecks++; if (out_data !== 64'd0) $display("[TB] FAIL midreset_data: got %h expected 0", out_data); else nPass++;
        nChecks++; if (out_clip !== 2'b00) $display("[TB] FAIL midreset_clip: got %b expected 00", out_clip); else nPass++;
        nChecks++; if (fx_active !== 1'b0) $display("[TB] FAIL midreset_fx: got %b expected 0", fx_active); else nPass++;

        resetn = 1'b1; enable = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL dropped_frame[%0d]: got %b expected 0", i, out_valid); else nPass++;
        end

        in_valid = 1'b1; in_data = {32'h7FFFFFFF, 32'h80000000};
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL latency_c1: got %b expected 0", out_valid); else nPass++;
        @(negedge CLOCK_50);
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL latency_c2: got %b expected 0", out_valid); else nPass++;
        @(negedge CLOCK_50);
        nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL latency_c3: got %b expected 1", out_valid); else nPass++;
        nChecks++; if (out_data !== {32'h7FFFFFFF, 32'h80000000}) $display("[TB] FAIL first_frame: got %h expected 7fffffff80000000", out_data); else nPass++;
        nChecks++; if (out_clip !== 2'b11) $display("[TB] FAIL first_clip: got %b expected 11", out_clip); else nPass++;
        idle(4);
    endtask

    task automatic test_bypass;
        logic [63:0] frames [3];
        frames[0] = {32'h12345678, 32'hFFFFFFFF};
        frames[1] = {32'h00000000, 32'h00000001};
        frames[2] = {32'hDEADBEEF, 32'h80000001};
        outQ.delete(); clipQ.delete();
        for (int i = 0; i < 3; i++) stream(frames[i], 1);
        idle(4);
        nChecks++; if (outQ.size() !== 3) $display("[TB] FAIL bypass_count: got %0d expected 3", outQ.size()); else nPass++;
        if (outQ.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                nChecks++; if (outQ[i] !== frames[i]) $display("[TB] FAIL bypass[%0d]: got %h expected %h", i, outQ[i], frames[i]); else nPass++;
            end
            nChecks++; if (clipQ[0] !== 2'b10) $display("[TB] FAIL bypass_clip: got %b expected 10", clipQ[0]); else nPass++;
        end
    endtask

    task automatic test_ramp_up;
        int expV [8] = '{20000000, 20742187, 21484375, 22226562, 22968750, 22968750, 22968750, 22968750};
        nChecks++; if (fx_active !== 1'b0) $display("[TB] FAIL ramp_fx_before: got %b expected 0", fx_active); else nPass++;
        outQ.delete(); clipQ.delete();
        enable = 1'b1; mode = 2'd0;
        stream({P20, P20}, 8);
        idle(4);
        nChecks++; if (outQ.size() !== 8) $display("[TB] FAIL ramp_count: got %0d expected 8", outQ.size()); else nPass++;
        if (outQ.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                nChecks++; if (outQ[k] !== {32'(expV[k]), 32'(expV[k])}) $display("[TB] FAIL ramp_up[%0d]: got %h expected %h", k, outQ[k], {32'(expV[k]), 32'(expV[k])}); else nPass++;
            end
        end
        nChecks++; if (fx_active !== 1'b1) $display("[TB] FAIL ramp_fx_after: got %b expected 1", fx_active); else nPass++;
    endtask

    task automatic test_mode_change;
        int expV [12] = '{22968750, 22226562, 21484375, 20742187, 20000000, 20000000,
                          19921875, 19843750, 19765625, 19687500, 19687500, 19687500};
        outQ.delete(); clipQ.delete();
        mode = 2'd1;
        stream({P20, P20}, 12);
        idle(4);
        nChecks++; if (outQ.size() !== 12) $display("[TB] FAIL remode_count: got %0d expected 12", outQ.size()); else nPass++;
        if (outQ.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                nChecks++; if (outQ[k] !== {32'(expV[k]), 32'(expV[k])}) $display("[TB] FAIL remode[%0d]: got %h expected %h", k, outQ[k], {32'(expV[k]), 32'(expV[k])}); else nPass++;
            end
        end
    endtask

    task automatic test_wet_modes;
        settle(1'b1, 2'd0, {N40, P20});
        stream({N40, P20}, 1); idle(4);
        nChecks++; if (outQ.size() !== 1 || outQ[0] !== {32'(-29531250), 32'd22968750}) $display("[TB] FAIL soft_wet: got %h expected %h", out_data, {32'(-29531250), 32'd22968750}); else nPass++;
        nChecks++; if (clipQ.size() !== 1 || clipQ[0] !== 2'b10) $display("[TB] FAIL soft_clip: got %b expected 10", out_clip); else nPass++;

        outQ.delete(); clipQ.delete();
        stream({32'h7FFFFFFF, 32'h80000000}, 1); idle(4);
        nChecks++; if (outQ.size() !== 1 || outQ[0] !== {32'd29531250, 32'(-29531250)}) $display("[TB] FAIL soft_edge: got %h expected %h", out_data, {32'd29531250, 32'(-29531250)}); else nPass++;
        nChecks++; if (clipQ.size() !== 1 || clipQ[0] !== 2'b11) $display("[TB] FAIL soft_edge_clip: got %b expected 11", out_clip); else nPass++;

        settle(1'b1, 2'd1, {N40, P20});
        stream({N40, P20}, 1); idle(4);
        nChecks++; if (outQ.size() !== 1 || outQ[0] !== {32'(-19687500), 32'd19687500}) $display("[TB] FAIL hard_wet: got %h expected %h", out_data, {32'(-19687500), 32'd19687500}); else nPass++;
        nChecks++; if (clipQ.size() !== 1 || clipQ[0] !== 2'b11) $display("[TB] FAIL hard_clip: got %b expected 11", out_clip); else nPass++;

        settle(1'b1, 2'd2, {32'd35000000, P20});
        stream({32'd35000000, P20}, 1); idle(4);
        nChecks++; if (outQ.size() !== 1 || outQ[0] !== {32'd0, 32'd13125000}) $display("[TB] FAIL fold_wet: got %h expected %h", out_data, {32'd0, 32'd13125000}); else nPass++;
        nChecks++; if (clipQ.size() !== 1 || clipQ[0] !== 2'b10) $display("[TB] FAIL fold_clip: got %b expected 10", out_clip); else nPass++;
    endtask

    task automatic test_gaps;
        int expV [7] = '{20000000, 20742187, 21484375, 22226562, 21484375, 20742187, 20000000};
        settle(1'b0, 2'd2, {P20, P20});
        nChecks++; if (fx_active !== 1'b0) $display("[TB] FAIL gaps_fx_start: got %b expected 0", fx_active); else nPass++;
        mode = 2'd0; enable = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if (j == 3) enable = 1'b0;
            stream({P20, P20}, 1);
            idle(2);
        end
        idle(4);
        nChecks++; if (outQ.size() !== 7) $display("[TB] FAIL gaps_count: got %0d expected 7", outQ.size()); else nPass++;
        if (outQ.size() == 7) begin
            for (int k = 0; k < 7; k++) begin
                nChecks++; if (outQ[k] !== {32'(expV[k]), 32'(expV[k])}) $display("[TB] FAIL gaps[%0d]: got %h expected %h", k, outQ[k], {32'(expV[k]), 32'(expV[k])}); else nPass++;
            end
        end
        nChecks++; if (fx_active !== 1'b0) $display("[TB] FAIL gaps_fx_end: got %b expected 0", fx_active); else nPass++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_ramp_up();
        test_mode_change();
        test_wet_modes();
        test_gaps();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
